watchdog_window: RTL and testbench
==================================

# watchdog_window

Parametrised windowed watchdog timer for the f8 system, succeeding the fixed 16-bit watchdog. It adds a configurable counter width and prescaler, a kick register with a key and an optional early-kick window, a pre-timeout warning interrupt, a lock bit and a sticky reset-cause register. It sits on the 8-bit peripheral bus and drives the system reset together with power-on reset.

## Interface
- `WIDTH`, 16: counter/reload/window width. Must be 8, 16, 24 or 32.
- `PRESC_BITS`, 4: prescaler width. A tick occurs every 2^PRESC_BITS enabled cycles.
- `WARN_DIST`, 16: warning fires when a tick moves the counter to (2^WIDTH−1)−WARN_DIST.
- `KICK_KEY`, 8'h5A: only valid kick value.
- `clk`  in  1  system clock.
- `power_on_reset_n`  in  1  asynchronous, active-low power-on reset.
- `addr`  in  4  register address.
- `wdata`  in  8  write data.
- `we`  in  1  write strobe, one byte per cycle.
- `rdata`  out  8  combinational read of `addr`.
- `trap`  in  1  illegal-instruction trap.
- `reset`  out  1  system reset.
- `irq_warn`  out  1  level interrupt; equals status[5].

## Operation
- Address map:
  - 0x0–0x3: counter bytes, LSB first.
  - 0x4–0x7: reload bytes.
  - 0x8–0xB: window bytes.
  - 0xC: config, with [0] enable, [1] window_en, [7] lock.
  - 0xD: status.
  - 0xE: kick.
- Bytes at or above WIDTH/8 are read as 0 and ignore writes.
- Status bits:
  - [0] power-on, [1] timeout, [2] trap, [3] early kick, [4] bad key, [5] warn.
  - Sticky. Writing 1 to a bit clears it.
- Reset values:
  - On `power_on_reset_n` low: counter, reload and window are 0. Config is 0. Status is 8'h01. Prescaler is 0. `reset` is 1 and `irq_warn` is 0.
- Prescaler:
  - Increments while enable=1.
  - tick = prescaler all-ones and enable=1.
- On a tick:
  - Counter all-ones: timeout event, and counter ← reload.
  - Otherwise counter increments.
  - If the new value equals (2^WIDTH−1)−WARN_DIST, set status[5].
- Kick (write to 0xE):
  - wdata≠KICK_KEY: bad-key event.
  - wdata=KICK_KEY, window_en=1 and counter<window: early-kick event.
  - Otherwise valid: counter ← reload and prescaler ← 0.
- Lock:
  - With lock=1, writes to reload, window and config are ignored.
  - Lock clears only on power-on reset.
  - Counter, status and kick stay writable.
- Events:
  - Sources are timeout, trap, early kick and bad key.
  - Each sets its status bit and requests an internal reset.
  - Internal reset clears config[0] and the prescaler. Counter, reload, window, window_en, lock and status are kept.
- Priorities within one cycle:
  - A valid kick beats a tick: counter ← reload and there is no timeout.
  - A counter byte write beats the tick for that byte only. Unwritten bytes take the tick result.
  - Several events in one cycle set all their bits and produce one reset.
  - A status clear-write loses to a simultaneous set of the same bit.

## Timing
- `reset` = !power_on_reset_n OR internal_reset_q.
  - The power-on term is combinational and asynchronous.
  - internal_reset_q is registered: high for exactly one cycle, the cycle after the event.
- Register writes take effect at the next clock edge. `rdata` shows the new value from that edge.
- The first tick after enable comes 2^PRESC_BITS cycles after the config write edge.
- Timeout period from a valid kick is (2^WIDTH − reload)·2^PRESC_BITS cycles.
- Events are ignored while internal_reset_q=1. `trap` held high for several cycles gives back-to-back one-cycle pulses after each clear. Only the first pulse matters, because enable is already 0.

## Structure
- Package `watchdog_pkg`:
  - Register address localparams.
  - Status bit indices.
  - The config bit-index struct.
  - The cause enum.
- One sub-module, `wd_prescaler` (params PRESC_BITS; ports clk, power_on_reset_n, clr, en, tick). Everything else lives in the top.

## Test plan
- WIDTH=16, PRESC_BITS=4, reload=16'hFFF0, enable → reset pulse 16·16=256 cycles after enable; status=8'h02; config[0]=0.
- Window=16'h8000, window_en=1, reload=0, kick 5A at counter=16'h0010 → early-kick reset, status[3]=1; same kick at counter 16'h8001 → counter=0 and no reset.
- Kick 8'h33 → bad-key reset, status[4]=1, and the counter is unchanged.
- Counter=16'hFFEE (WARN_DIST=16), wait one tick → counter 16'hFFEF, irq_warn=1; write 8'h20 to 0xD → irq_warn=0.
- Lock=1, then write reload=16'h1234 → reload still reads back its old value; assert power_on_reset_n low mid-count → all registers back to reset values, status=8'h01.
- Valid kick coinciding with the overflow tick → no reset, counter=reload; trap in the same cycle as timeout → single pulse, status=8'h06.

Source files
------------

// File: rtl/watchdog_pkg.sv
// watchdog_pkg: register map, status bit indices (from cause codes), config layout and byte-read helper
package watchdog_pkg;
  typedef enum logic [2:0] {
    CAUSE_POR,
    CAUSE_TIMEOUT,
    CAUSE_TRAP,
    CAUSE_EARLY,
    CAUSE_BADKEY,
    CAUSE_WARN
  } cause_e;
  localparam logic [3:0] A_CNT = 4'h0, A_RELOAD = 4'h4, A_WINDOW = 4'h8;
  localparam logic [3:0] A_CFG = 4'hC, A_STATUS = 4'hD, A_KICK = 4'hE;
  localparam int ST_POR = CAUSE_POR;
  localparam int ST_TIMEOUT = CAUSE_TIMEOUT;
  localparam int ST_TRAP = CAUSE_TRAP;
  localparam int ST_EARLY = CAUSE_EARLY;
  localparam int ST_BADKEY = CAUSE_BADKEY;
  localparam int ST_WARN = CAUSE_WARN;
  localparam logic [7:0] STATUS_MASK = 8'h3F;
  typedef struct packed {
    logic lock;
    logic [4:0] rsvd;
    logic window_en;
    logic enable;
  } cfg_t;
  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] b);
    return v[{b, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/wd_prescaler.sv
// wd_prescaler: free-running divider; tick when all-ones and en (clk, power_on_reset_n, clr, en -> tick)
module wd_prescaler #(
  parameter int PRESC_BITS = 4
) (
  input  logic clk,
  input  logic power_on_reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  always_comb begin
    presc_d = (clr || !en) ? '0 : presc_q + PRESC_BITS'(1);
    tick = en && &presc_q;
  end
  always_ff @(posedge clk or negedge power_on_reset_n)
    if (!power_on_reset_n) presc_q <= '0;
    else presc_q <= presc_d;
endmodule

// File: rtl/watchdog_window.sv
// watchdog_window: windowed watchdog on 8-bit bus (addr/wdata/we/rdata, trap in; reset, irq_warn out)
module watchdog_window
  import watchdog_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PRESC_BITS = 4,
  parameter int WARN_DIST = 16,
  parameter logic [7:0] KICK_KEY = 8'h5A
) (
  input  logic       clk,
  input  logic       power_on_reset_n,
  input  logic [3:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata,
  input  logic       trap,
  output logic       reset,
  output logic       irq_warn
);
  localparam int NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] WARN_VAL = {WIDTH{1'b1}} - WIDTH'(WARN_DIST);
  logic [WIDTH-1:0] counter_q, counter_d, reload_q, reload_d, window_q, window_d, tick_val;
  cfg_t cfg_q, cfg_d;
  logic [7:0] status_q, status_d, ev_set, ev_clr;
  logic internal_reset_q, internal_reset_d;
  logic tick, kick, key_ok, too_early, kick_ok, ovf, live, event_any;
  function automatic logic [WIDTH-1:0] put_byte(input logic [WIDTH-1:0] v, input logic [1:0] b,
                                                input logic [7:0] d);
    put_byte = v;
    for (int i = 0; i < NB; i++) if (b == 2'(i)) put_byte[i*8 +: 8] = d;
  endfunction
  wd_prescaler #(.PRESC_BITS(PRESC_BITS)) u_presc (
    .clk(clk),
    .power_on_reset_n(power_on_reset_n),
    .clr(kick_ok || event_any),
    .en(cfg_q.enable),
    .tick(tick)
  );
  always_comb begin
    kick = we && addr == A_KICK;
    key_ok = wdata == KICK_KEY;
    too_early = cfg_q.window_en && counter_q < window_q;
    kick_ok = kick && key_ok && !too_early;
    ovf = &counter_q;
    tick_val = ovf ? reload_q : counter_q + WIDTH'(1);
    live = !internal_reset_q;
    ev_set = '0;
    ev_set[ST_TIMEOUT] = live && tick && ovf && !kick_ok;
    ev_set[ST_TRAP] = live && trap;
    ev_set[ST_EARLY] = live && kick && key_ok && too_early;
    ev_set[ST_BADKEY] = live && kick && !key_ok;
    ev_set[ST_WARN] = tick && !kick_ok && tick_val == WARN_VAL;
    event_any = |ev_set[ST_BADKEY:ST_TIMEOUT];
    ev_clr = (we && addr == A_STATUS) ? wdata : '0;
    status_d = ((status_q & ~ev_clr) | ev_set) & STATUS_MASK;
    counter_d = kick_ok ? reload_q : tick ? tick_val : counter_q;
    counter_d = (we && addr[3:2] == A_CNT[3:2]) ? put_byte(counter_d, addr[1:0], wdata) : counter_d;
    reload_d = (we && !cfg_q.lock && addr[3:2] == A_RELOAD[3:2]) ?
               put_byte(reload_q, addr[1:0], wdata) : reload_q;
    window_d = (we && !cfg_q.lock && addr[3:2] == A_WINDOW[3:2]) ?
               put_byte(window_q, addr[1:0], wdata) : window_q;
    cfg_d = (we && !cfg_q.lock && addr == A_CFG) ? cfg_t'({wdata[7], 5'b0, wdata[1:0]}) : cfg_q;
    cfg_d.enable = cfg_d.enable && !event_any;
    internal_reset_d = event_any;
    rdata = addr[3:2] == A_CNT[3:2]    ? byte_of(32'(counter_q), addr[1:0]) :
            addr[3:2] == A_RELOAD[3:2] ? byte_of(32'(reload_q), addr[1:0]) :
            addr[3:2] == A_WINDOW[3:2] ? byte_of(32'(window_q), addr[1:0]) :
            addr == A_CFG              ? cfg_q :
            addr == A_STATUS           ? status_q : 8'h00;
  end
  always_ff @(posedge clk or negedge power_on_reset_n)
    if (!power_on_reset_n) begin
      counter_q <= '0;
      reload_q <= '0;
      window_q <= '0;
      cfg_q <= '0;
      status_q <= 8'h01;
      internal_reset_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      reload_q <= reload_d;
      window_q <= window_d;
      cfg_q <= cfg_d;
      status_q <= status_d;
      internal_reset_q <= internal_reset_d;
    end
  assign reset = !power_on_reset_n || internal_reset_q;
  assign irq_warn = status_q[ST_WARN];
endmodule

// File: tb/tb_watchdog_window.sv
// tb_watchdog_window: directed and random checks of watchdog_window against a behavioural model
module tb_watchdog_window;
  localparam int W = 16, PB = 4, WD = 16;
  localparam logic [7:0] KEY = 8'h5A;
  localparam longint MAX = (longint'(1) << W) - 1;
  logic clk = 0, power_on_reset_n = 0, we = 0, trap = 0, reset, irq_warn;
  logic [3:0] addr = 0;
  logic [7:0] wdata = 0, rdata;
  int checks = 0, errors = 0, n;
  longint m_cnt, m_rel, m_win;
  int m_presc, m_status;
  bit m_en, m_wen, m_lock, m_irst;
  watchdog_window #(.WIDTH(W), .PRESC_BITS(PB), .WARN_DIST(WD), .KICK_KEY(KEY)) dut (
    .clk(clk), .power_on_reset_n(power_on_reset_n), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .trap(trap), .reset(reset), .irq_warn(irq_warn)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic m_por();
    m_cnt = 0; m_rel = 0; m_win = 0; m_presc = 0;
    m_en = 0; m_wen = 0; m_lock = 0; m_irst = 0; m_status = 1;
  endtask
  function automatic longint put(input longint v, input int b, input int d);
    return (v & ~(longint'(255) << (8 * b))) | (longint'(d) << (8 * b));
  endfunction
  function automatic int m_read(input int a);
    if (a < 12) begin
      longint v = a < 4 ? m_cnt : a < 8 ? m_rel : m_win;
      return (a % 4) < W / 8 ? int'((v >> (8 * (a % 4))) & 255) : 0;
    end
    if (a == 12) return int'({m_lock, 5'b0, m_wen, m_en});
    if (a == 13) return m_status;
    return 0;
  endfunction
  task automatic m_next(input bit w, input int a, input int d, input bit t);
    bit tk, kick, good, early, ok, evt;
    longint tv, nc;
    int sets;
    tk = m_en && m_presc == (1 << PB) - 1;
    kick = w && a == 14;
    good = kick && d == int'(KEY);
    early = good && m_wen && m_cnt < m_win;
    ok = good && !early;
    tv = (m_cnt == MAX) ? m_rel : m_cnt + 1;
    sets = 0;
    if (!m_irst)
      sets = (tk && m_cnt == MAX && !ok ? 2 : 0) | (t ? 4 : 0) | (early ? 8 : 0) | (kick && !good ? 16 : 0);
    if (tk && !ok && tv == MAX - WD) sets |= 32;
    evt = (sets & 30) != 0;
    nc = ok ? m_rel : tk ? tv : m_cnt;
    if (w && a < W / 8) nc = put(nc, a, d);
    if (w && !m_lock && a >= 4 && a < 4 + W / 8) m_rel = put(m_rel, a - 4, d);
    if (w && !m_lock && a >= 8 && a < 8 + W / 8) m_win = put(m_win, a - 8, d);
    m_presc = (ok || evt || !m_en) ? 0 : (m_presc + 1) % (1 << PB);
    if (w && a == 12 && !m_lock) begin
      m_en = d[0]; m_wen = d[1]; m_lock = d[7];
    end
    if (evt) m_en = 0;
    m_status = ((m_status & ~(w && a == 13 ? d : 0)) | sets) & 63;
    m_cnt = nc;
    m_irst = evt;
  endtask
  task automatic step(input bit w, input logic [3:0] a, input logic [7:0] d, input bit t);
    we = w; addr = a; wdata = d; trap = t;
    m_next(w, int'(a), int'(d), t);
    @(posedge clk);
    #1;
    chk("reset", reset, m_irst);
    chk("irq_warn", irq_warn, m_status[5]);
    chk($sformatf("rdata@%0h", a), rdata, m_read(int'(a)));
    @(negedge clk);
    we = 0; trap = 0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input longint exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end
  initial begin
    m_por();
    repeat (2) @(negedge clk);
    #1;
    chk("por_reset", reset, 1);
    chk("por_warn", irq_warn, 0);
    rd("por_status", 4'hD, 8'h01);
    rd("por_cnt", 4'h0, 8'h00);
    @(negedge clk);
    power_on_reset_n = 1;
    step(1, 4'hD, 8'h01, 0);
    step(1, 4'h4, 8'hF0, 0); step(1, 4'h5, 8'hFF, 0);
    step(1, 4'h0, 8'hF0, 0); step(1, 4'h1, 8'hFF, 0);
    step(1, 4'hC, 8'h01, 0);
    n = 0;
    while (reset !== 1'b1 && n < 400) begin
      step(0, 4'h0, 8'h00, 0);
      n++;
    end
    chk("timeout_cycles", n, 256);
    rd("to_status", 4'hD, 8'h02);
    rd("to_cfg", 4'hC, 8'h00);
    rd("to_cnt_hi", 4'h1, 8'hFF);
    step(1, 4'hD, 8'hFF, 0);
    step(1, 4'h4, 8'h00, 0); step(1, 4'h5, 8'h00, 0);
    step(1, 4'h8, 8'h00, 0); step(1, 4'h9, 8'h80, 0);
    step(1, 4'h0, 8'h10, 0); step(1, 4'h1, 8'h00, 0);
    step(1, 4'hC, 8'h03, 0);
    step(1, 4'hE, KEY, 0);
    chk("early_reset", reset, 1);
    rd("early_status", 4'hD, 8'h08);
    step(1, 4'h0, 8'h01, 0); step(1, 4'h1, 8'h80, 0);
    step(1, 4'hE, KEY, 0);
    chk("late_kick_reset", reset, 0);
    rd("late_cnt_lo", 4'h0, 8'h00);
    rd("late_cnt_hi", 4'h1, 8'h00);
    step(1, 4'h0, 8'h34, 0);
    step(1, 4'hE, 8'h33, 0);
    chk("badkey_reset", reset, 1);
    rd("badkey_status", 4'hD, 8'h18);
    rd("badkey_cnt", 4'h0, 8'h34);
    step(1, 4'hD, 8'hFF, 0);
    step(1, 4'h0, 8'hEE, 0); step(1, 4'h1, 8'hFF, 0);
    step(1, 4'hC, 8'h01, 0);
    repeat (16) step(0, 4'h0, 8'h00, 0);
    chk("warn_irq", irq_warn, 1);
    rd("warn_cnt", 4'h0, 8'hEF);
    step(1, 4'hD, 8'h20, 0);
    chk("warn_clr", irq_warn, 0);
    step(1, 4'hC, 8'h00, 0);
    step(1, 4'h4, 8'h34, 0); step(1, 4'h5, 8'h12, 0);
    step(1, 4'h0, 8'hFF, 0); step(1, 4'h1, 8'hFF, 0);
    step(1, 4'hC, 8'h01, 0);
    repeat (15) step(0, 4'h0, 8'h00, 0);
    step(1, 4'hE, KEY, 0);
    chk("ovf_kick_reset", reset, 0);
    rd("ovf_cnt_lo", 4'h0, 8'h34);
    rd("ovf_cnt_hi", 4'h1, 8'h12);
    rd("ovf_status", 4'hD, 8'h00);
    step(1, 4'hC, 8'h00, 0);
    step(1, 4'h0, 8'hFF, 0); step(1, 4'h1, 8'hFF, 0);
    step(1, 4'hC, 8'h01, 0);
    repeat (15) step(0, 4'h0, 8'h00, 0);
    step(0, 4'h0, 8'h00, 1);
    chk("trap_to_reset", reset, 1);
    step(0, 4'h0, 8'h00, 0);
    chk("single_pulse", reset, 0);
    rd("trap_to_status", 4'hD, 8'h06);
    rd("trap_to_cnt", 4'h1, 8'h12);
    step(1, 4'hD, 8'hFF, 0);
    step(1, 4'h4, 8'hAA, 0); step(1, 4'h5, 8'h00, 0);
    step(1, 4'hC, 8'h81, 0);
    step(1, 4'h4, 8'h34, 0); step(1, 4'h5, 8'h12, 0);
    step(1, 4'hC, 8'h00, 0);
    rd("lock_rel_lo", 4'h4, 8'hAA);
    rd("lock_rel_hi", 4'h5, 8'h00);
    rd("lock_cfg", 4'hC, 8'h81);
    repeat (40) step(0, 4'h0, 8'h00, 0);
    power_on_reset_n = 0;
    #1;
    chk("por2_reset", reset, 1);
    m_por();
    rd("por2_status", 4'hD, 8'h01);
    rd("por2_cfg", 4'hC, 8'h00);
    rd("por2_rel", 4'h4, 8'h00);
    @(negedge clk);
    power_on_reset_n = 1;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      bit w, t;
      if (i == 750) begin
        power_on_reset_n = 0;
        #1;
        chk("rand_por_reset", reset, 1);
        m_por();
        @(negedge clk);
        power_on_reset_n = 1;
      end
      a = 4'($urandom_range(0, 15));
      w = $urandom_range(0, 1) == 1;
      d = 8'($urandom);
      t = $urandom_range(0, 63) == 0;
      if (a == 4'hE && $urandom_range(0, 1) == 1) d = KEY;
      if (a == 4'hC) d = (d & 8'h03) | ($urandom_range(0, 15) == 0 ? 8'h80 : 8'h00)
                         | ($urandom_range(0, 2) != 0 ? 8'h01 : 8'h00);
      if (a == 4'h1 && $urandom_range(0, 3) != 0) d = 8'hFF;
      step(w, a, d, t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
